// File: rtl/sram_arb_pkg.sv
// Shared types and widths for the IFU/LSU sram arbiter.
package sram_arb_pkg;

    localparam int XLEN   = 32;
    localparam int MASK_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } arb_state_t;

    typedef enum logic {
        GNT_IFU,
        GNT_LSU
    } arb_gnt_t;

endpackage

// File: rtl/sram_arb_pick.sv
// Winner selection between IFU and LSU requests.
module sram_arb_pick
    import sram_arb_pkg::*;
#(
    parameter bit LSU_FIRST = 1'b1
) (
    input  logic     ifu_req,
    input  logic     lsu_req,
    input  arb_gnt_t last_grant,
    output logic     gnt_valid,
    output arb_gnt_t gnt_id
);

    always_comb begin
        gnt_valid = ifu_req | lsu_req;
        gnt_id    = GNT_IFU;
        if (ifu_req && lsu_req) begin
            // Round-robin hands the tie to whoever was not served last.
            if (LSU_FIRST || last_grant == GNT_IFU) begin
                gnt_id = GNT_LSU;
            end else begin
                gnt_id = GNT_IFU;
            end
        end else if (lsu_req) begin
            gnt_id = GNT_LSU;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Single-port sram shared by IFU (read) and LSU (read/write).
// One transaction at a time, with a forced idle cycle between them.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter bit LSU_FIRST = 1'b1,
    parameter int TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req,
    input  logic [XLEN-1:0]   ifu_addr,
    output logic [XLEN-1:0]   ifu_rdata,
    output logic              ifu_done,
    output logic              ifu_err,
    input  logic              lsu_req,
    input  logic              lsu_wen,
    input  logic [XLEN-1:0]   lsu_addr,
    input  logic [XLEN-1:0]   lsu_wdata,
    input  logic [MASK_W-1:0] lsu_wmask,
    output logic [XLEN-1:0]   lsu_rdata,
    output logic              lsu_done,
    output logic              lsu_err,
    output logic              s_ren,
    output logic              s_wen,
    output logic [MASK_W-1:0] s_wmask,
    output logic [XLEN-1:0]   s_addr,
    output logic [XLEN-1:0]   s_wdata,
    input  logic [XLEN-1:0]   s_data,
    input  logic              s_valid
);

    localparam int            CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);

    arb_state_t        state;
    arb_gnt_t          last_grant;
    arb_gnt_t          gnt_l;
    logic              wen_l;
    logic              err_l;
    logic [XLEN-1:0]   addr_l;
    logic [XLEN-1:0]   wdata_l;
    logic [XLEN-1:0]   rdata_l;
    logic [MASK_W-1:0] wmask_l;
    logic [CW-1:0]     cnt;

    logic              gnt_valid;
    arb_gnt_t          gnt_id;
    logic              busy;
    logic              done;

    sram_arb_pick #(
        .LSU_FIRST (LSU_FIRST)
    ) u_pick (
        .ifu_req    (ifu_req),
        .lsu_req    (lsu_req),
        .last_grant (last_grant),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            last_grant <= GNT_IFU;
            gnt_l      <= GNT_IFU;
            wen_l      <= 1'b0;
            err_l      <= 1'b0;
            addr_l     <= '0;
            wdata_l    <= '0;
            rdata_l    <= '0;
            wmask_l    <= '0;
            cnt        <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        state      <= ST_BUSY;
                        gnt_l      <= gnt_id;
                        last_grant <= gnt_id;
                        cnt        <= '0;
                        err_l      <= 1'b0;
                        rdata_l    <= '0;
                        if (gnt_id == GNT_LSU) begin
                            addr_l  <= lsu_addr;
                            wdata_l <= lsu_wdata;
                            wmask_l <= lsu_wmask;
                            wen_l   <= lsu_wen;
                        end else begin
                            addr_l  <= ifu_addr;
                            wdata_l <= '0;
                            wmask_l <= '0;
                            wen_l   <= 1'b0;
                        end
                    end
                end
                ST_BUSY: begin
                    if (s_valid) begin
                        state   <= ST_DONE;
                        rdata_l <= wen_l ? '0 : s_data;
                    end else if (cnt == CNT_LAST) begin
                        state   <= ST_DONE;
                        err_l   <= 1'b1;
                        rdata_l <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == ST_BUSY);
    assign done = (state == ST_DONE);

    // Enables exist only in BUSY, so DONE always drops them for a cycle.
    assign s_ren   = busy & ~wen_l;
    assign s_wen   = busy & wen_l;
    assign s_wmask = s_wen ? wmask_l : '0;
    assign s_addr  = busy ? addr_l : '0;
    assign s_wdata = busy ? wdata_l : '0;

    assign ifu_done  = done & (gnt_l == GNT_IFU);
    assign ifu_err   = ifu_done & err_l;
    assign ifu_rdata = ifu_done ? rdata_l : '0;

    assign lsu_done  = done & (gnt_l == GNT_LSU);
    assign lsu_err   = lsu_done & err_l;
    assign lsu_rdata = lsu_done ? rdata_l : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: fixed-priority DUT plus a
// round-robin DUT, each with a one-cycle-latency sram model.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        ifu_req, ifu_done, ifu_err;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req, lsu_wen, lsu_done, lsu_err;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [7:0]  lsu_wmask;
    logic        s_ren, s_wen, s_valid;
    logic [7:0]  s_wmask;
    logic [31:0] s_addr, s_wdata, s_data;

    logic        rr_ifu_req, rr_ifu_done, rr_ifu_err;
    logic [31:0] rr_ifu_rdata;
    logic        rr_lsu_req, rr_lsu_done, rr_lsu_err;
    logic [31:0] rr_lsu_rdata;
    logic        rr_s_ren, rr_s_wen, rr_s_valid;
    logic [7:0]  rr_s_wmask;
    logic [31:0] rr_s_addr, rr_s_wdata;

    always #5 clk = ~clk;

    sram_arbiter #(.LSU_FIRST(1'b1), .TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .ifu_req   (ifu_req),
        .ifu_addr  (ifu_addr),
        .ifu_rdata (ifu_rdata),
        .ifu_done  (ifu_done),
        .ifu_err   (ifu_err),
        .lsu_req   (lsu_req),
        .lsu_wen   (lsu_wen),
        .lsu_addr  (lsu_addr),
        .lsu_wdata (lsu_wdata),
        .lsu_wmask (lsu_wmask),
        .lsu_rdata (lsu_rdata),
        .lsu_done  (lsu_done),
        .lsu_err   (lsu_err),
        .s_ren     (s_ren),
        .s_wen     (s_wen),
        .s_wmask   (s_wmask),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_data    (s_data),
        .s_valid   (s_valid)
    );

    sram_arbiter #(.LSU_FIRST(1'b0), .TIMEOUT(16)) dut_rr (
        .clk       (clk),
        .rst       (rst),
        .ifu_req   (rr_ifu_req),
        .ifu_addr  (32'h8000_0000),
        .ifu_rdata (rr_ifu_rdata),
        .ifu_done  (rr_ifu_done),
        .ifu_err   (rr_ifu_err),
        .lsu_req   (rr_lsu_req),
        .lsu_wen   (1'b0),
        .lsu_addr  (32'h8000_0004),
        .lsu_wdata (32'h0),
        .lsu_wmask (8'h0),
        .lsu_rdata (rr_lsu_rdata),
        .lsu_done  (rr_lsu_done),
        .lsu_err   (rr_lsu_err),
        .s_ren     (rr_s_ren),
        .s_wen     (rr_s_wen),
        .s_wmask   (rr_s_wmask),
        .s_addr    (rr_s_addr),
        .s_wdata   (rr_s_wdata),
        .s_data    (32'hC0DE_0000),
        .s_valid   (rr_s_valid)
    );

    // sram model: valid and data one cycle after an enable
    logic [31:0] mem [0:15];
    bit          hold;

    always @(posedge clk or negedge rst) begin : sram
        logic [31:0] w;
        if (!rst) begin
            s_valid <= 1'b0;
            s_data  <= 32'h0;
            for (int k = 0; k < 16; k++) mem[k] <= 32'h0;
            mem[0] <= 32'hDEAD_BEEF;
            mem[1] <= 32'h1111_1111;
            mem[2] <= 32'h2222_2222;
            mem[3] <= 32'h3333_3333;
            mem[4] <= 32'hAAAA_AAAA;
            mem[8] <= 32'h5A5A_5A5A;
        end else begin
            s_valid <= 1'b0;
            if (!hold && s_ren) begin
                s_valid <= 1'b1;
                s_data  <= mem[s_addr[5:2]];
            end
            if (!hold && s_wen) begin
                s_valid <= 1'b1;
                w = mem[s_addr[5:2]];
                for (int b = 0; b < 4; b++)
                    if (s_wmask[b]) w[8*b +: 8] = s_wdata[8*b +: 8];
                mem[s_addr[5:2]] <= w;
            end
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) rr_s_valid <= 1'b0;
        else      rr_s_valid <= rr_s_ren | rr_s_wen;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit          lsu;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t sb[$];

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst && (ifu_done || lsu_done)) begin
            check("dual_done", ifu_done & lsu_done, 0);
            if (sb.size() == 0) begin
                check("spurious_done", {ifu_done, lsu_done}, 0);
            end else begin
                e = sb.pop_front();
                check("sb_master", lsu_done, e.lsu);
                check("sb_rdata", lsu_done ? lsu_rdata : ifu_rdata, e.rdata);
                check("sb_err", lsu_done ? lsu_err : ifu_err, e.err);
                check("other_rdata", lsu_done ? ifu_rdata : lsu_rdata, 0);
            end
        end
    end

    // Called #1 after a posedge; returns #1 after the edge ending done.
    task automatic txn(input bit lsu, input bit wen,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [7:0] wmask, input logic [31:0] exp_rdata,
                       input bit exp_err, input int exp_lat);
        int  lat;
        int  en;
        bit  seen;
        lat  = -1;
        en   = 0;
        seen = 1'b0;
        sb.push_back(exp_t'{lsu, exp_rdata, exp_err});
        if (lsu) begin
            lsu_req   = 1'b1;
            lsu_wen   = wen;
            lsu_addr  = addr;
            lsu_wdata = wdata;
            lsu_wmask = wmask;
        end else begin
            ifu_req  = 1'b1;
            ifu_addr = addr;
        end
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (i == 0) check("gap_idle", {s_ren, s_wen}, 0);
            if (i == 1) begin
                lsu_addr  = ~addr;
                lsu_wdata = ~wdata;
                lsu_wmask = ~wmask;
                ifu_addr  = ~addr;
            end
            if (s_ren || s_wen) begin
                en++;
                check("s_addr", s_addr, addr);
                check("s_dir", {s_ren, s_wen}, wen ? 2'b01 : 2'b10);
                if (wen) begin
                    check("s_wmask", s_wmask, wmask);
                    check("s_wdata", s_wdata, wdata);
                end else begin
                    check("s_rmask", s_wmask, 0);
                end
            end
            if (lsu ? lsu_done : ifu_done) begin
                seen = 1'b1;
                lat  = i;
                break;
            end
        end
        check("done_seen", seen, 1);
        check("latency", lat, exp_lat);
        check("en_cycles", en, exp_lat - 1);
        @(posedge clk);
        #1;
        ifu_req = 1'b0;
        lsu_req = 1'b0;
    endtask

    initial begin
        ifu_req = 0; ifu_addr = 0;
        lsu_req = 0; lsu_wen = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wmask = 0;
        rr_ifu_req = 0; rr_lsu_req = 0;
        hold = 1'b0;
        rst  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ren", s_ren, 0);
        check("rst_wen", s_wen, 0);
        check("rst_wmask", s_wmask, 0);
        check("rst_addr", s_addr, 0);
        check("rst_done", {ifu_done, lsu_done}, 0);
        check("rst_rdata", ifu_rdata | lsu_rdata, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // single IFU read
        txn(0, 0, 32'h8000_0000, 0, 0, 32'hDEAD_BEEF, 0, 3);

        // LSU writes with IFU/LSU readback
        txn(1, 1, 32'h8000_0010, 32'h1234_5678, 8'h0F, 0, 0, 3);
        txn(0, 0, 32'h8000_0010, 0, 0, 32'h1234_5678, 0, 3);
        txn(1, 1, 32'h8000_0010, 32'hCAFE_F00D, 8'h03, 0, 0, 3);
        txn(1, 0, 32'h8000_0010, 0, 0, 32'h1234_F00D, 0, 3);

        // back-to-back IFU reads
        txn(0, 0, 32'h8000_0004, 0, 0, 32'h1111_1111, 0, 3);
        txn(0, 0, 32'h8000_0008, 0, 0, 32'h2222_2222, 0, 3);
        txn(0, 0, 32'h8000_000C, 0, 0, 32'h3333_3333, 0, 3);

        // simultaneous requests, fixed priority
        begin : prio
            int ldone;
            bit iseen;
            ldone = 0;
            iseen = 1'b0;
            repeat (3) sb.push_back(exp_t'{1'b1, 32'h5A5A_5A5A, 1'b0});
            lsu_req  = 1'b1;
            lsu_wen  = 1'b0;
            lsu_addr = 32'h8000_0020;
            ifu_req  = 1'b1;
            ifu_addr = 32'h8000_0000;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (lsu_done) begin
                    check("prio_lsu_cyc", i, 3 + 4 * ldone);
                    ldone++;
                    if (ldone == 3) begin
                        sb.push_back(exp_t'{1'b0, 32'hDEAD_BEEF, 1'b0});
                        @(posedge clk);
                        #1;
                        lsu_req = 1'b0;
                    end
                end
                if (ifu_done) begin
                    check("prio_ifu_cyc", i, 15);
                    iseen = 1'b1;
                    break;
                end
            end
            check("prio_lsu_count", ldone, 3);
            check("prio_ifu_seen", iseen, 1);
            @(posedge clk);
            #1;
            ifu_req = 1'b0;
        end

        // timeout
        hold = 1'b1;
        txn(0, 0, 32'h8000_0020, 0, 0, 0, 1, 16);
        hold = 1'b0;

        // reset mid-read
        hold     = 1'b1;
        ifu_req  = 1'b1;
        ifu_addr = 32'h8000_0000;
        repeat (3) @(negedge clk);
        check("pre_rst_ren", s_ren, 1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_ren", s_ren, 0);
        check("async_rst_done", ifu_done, 0);
        @(negedge clk);
        check("rst_hold_done", ifu_done, 0);
        #2;
        ifu_req = 1'b0;
        hold    = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        check("post_rst_done", ifu_done, 0);
        @(posedge clk);
        #1;
        txn(0, 0, 32'h8000_0000, 0, 0, 32'hDEAD_BEEF, 0, 3);

        // round-robin instance, both held high
        begin : rr
            int got;
            got = 0;
            rr_ifu_req = 1'b1;
            rr_lsu_req = 1'b1;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (rr_ifu_done || rr_lsu_done) begin
                    check("rr_gnt", rr_lsu_done, (got % 2) == 0);
                    check("rr_cyc", i, 3 + 4 * got);
                    check("rr_rdata", rr_lsu_done ? rr_lsu_rdata : rr_ifu_rdata,
                          32'hC0DE_0000);
                    got++;
                    if (got == 4) break;
                end
            end
            check("rr_count", got, 4);
            @(posedge clk);
            #1;
            rr_ifu_req = 1'b0;
            rr_lsu_req = 1'b0;
        end

        repeat (3) @(posedge clk);
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
